phase_interval_timer: RTL and testbench

//  Parametrised multi-phase interval counter for the traffic-light controller.

---
 rtl/phase_interval_timer.sv | 128 ++++++++++++
 tb/tb_phase_interval_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_interval_timer.sv
// Multi-phase interval counter for the traffic-light controller.
// Counts prescaled ticks inside the current phase against a per-phase
// terminal count (normal, or extended while a pedestrian request is latched),
// wraps to zero on terminal, advances the phase and pulses phase_done.

// Per-phase limit lane: presents its phase's active limit when selected,
// zero otherwise, so the top can OR all lanes together.
module pit_phase_lim #(
  parameter int WIDTH = 6,
  parameter int PW    = 2,
  parameter int IDX   = 0
) (
  input  logic [PW-1:0]    phase_i,
  input  logic             req_i,
  input  logic [WIDTH-1:0] norm_i,
  input  logic [WIDTH-1:0] ext_i,
  output logic [WIDTH-1:0] lim_o
);
  logic sel;
  assign sel   = (phase_i == PW'(IDX));
  assign lim_o = sel ? (req_i ? ext_i : norm_i) : '0;
endmodule

module phase_interval_timer #(
  parameter int WIDTH  = 6,
  parameter int NPHASE = 4,
  parameter int PW     = $clog2(NPHASE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    tick_en,
  input  logic                    hold,
  input  logic                    button,
  input  logic [NPHASE*WIDTH-1:0] lim_norm,
  input  logic [NPHASE*WIDTH-1:0] lim_ext,
  output logic [WIDTH-1:0]        count,
  output logic [PW-1:0]           phase,
  output logic                    phase_done,
  output logic                    req_pending
);

  logic [WIDTH-1:0]               count_q, count_d;
  logic [PW-1:0]                  phase_q, phase_d;
  logic                           done_q, done_d;
  logic                           req_q, req_d;

  logic [NPHASE-1:0][WIDTH-1:0]   lane_lim;
  logic [WIDTH-1:0]               act_lim;
  logic [PW-1:0]                  phase_nxt;
  logic                           advance;
  logic                           terminal;

  // One limit lane per phase; only the lane matching phase_q is non-zero.
  generate
    for (genvar k = 0; k < NPHASE; k++) begin : g_lane
      pit_phase_lim #(
        .WIDTH (WIDTH),
        .PW    (PW),
        .IDX   (k)
      ) u_lim (
        .phase_i (phase_q),
        .req_i   (req_q),
        .norm_i  (lim_norm[k*WIDTH +: WIDTH]),
        .ext_i   (lim_ext[k*WIDTH +: WIDTH]),
        .lim_o   (lane_lim[k])
      );
    end
  endgenerate

  // Merge the one-hot lane outputs into the active limit.
  always_comb begin
    act_lim = '0;
    for (int k = 0; k < NPHASE; k++) act_lim = act_lim | lane_lim[k];
  end

  // >= rather than == so a limit lowered under the current count still ends
  // the phase on the next tick; it also keeps count+1 from overflowing since
  // count never passes an all-ones limit.
  assign advance   = tick_en & ~hold;
  assign terminal  = (count_q >= act_lim);
  assign phase_nxt = (phase_q == PW'(NPHASE-1)) ? '0 : phase_q + PW'(1);

  // Next-state: clear beats hold beats tick; request latches on any
  // non-terminal cycle and is consumed (but re-armed by a same-cycle press)
  // on terminal.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    req_d   = req_q | button;
    if (clear) begin
      count_d = '0;
      phase_d = '0;
      req_d   = 1'b0;
    end else if (advance) begin
      if (terminal) begin
        count_d = '0;
        phase_d = phase_nxt;
        done_d  = 1'b1;
        req_d   = button;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      phase_q <= '0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      done_q  <= done_d;
      req_q   <= req_d;
    end
  end

  assign count       = count_q;
  assign phase       = phase_q;
  assign phase_done  = done_q;
  assign req_pending = req_q;

endmodule

// File: tb/tb_phase_interval_timer.sv
// Directed bench for phase_interval_timer: a cycle model derived from the
// behavioural rules is checked on every falling edge, and hand-computed
// milestones pin the model at the end of each scenario.
module tb_phase_interval_timer;
  localparam int WIDTH  = 6;
  localparam int NPHASE = 4;
  localparam int PW     = 2;

  logic                    clk = 1'b0;
  logic                    reset, clear, tick_en, hold, button;
  logic [NPHASE*WIDTH-1:0] lim_norm, lim_ext;
  logic [WIDTH-1:0]        count;
  logic [PW-1:0]           phase;
  logic                    phase_done, req_pending;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  // model state
  int m_cnt, m_ph, m_done, m_req;

  phase_interval_timer #(.WIDTH(WIDTH), .NPHASE(NPHASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .tick_en     (tick_en),
    .hold        (hold),
    .button      (button),
    .lim_norm    (lim_norm),
    .lim_ext     (lim_ext),
    .count       (count),
    .phase       (phase),
    .phase_done  (phase_done),
    .req_pending (req_pending)
  );

  always #5 clk = ~clk;

  function automatic int lim_of(input logic [NPHASE*WIDTH-1:0] v, input int ph);
    return int'(v[ph*WIDTH +: WIDTH]);
  endfunction

  // Behavioural model: phases of L+1 ticks, request consumed at phase end.
  always @(posedge clk or posedge reset) begin
    int lim;
    if (reset) begin
      m_cnt = 0; m_ph = 0; m_done = 0; m_req = 0;
    end else if (clear) begin
      m_cnt = 0; m_ph = 0; m_done = 0; m_req = 0;
    end else begin
      lim = (m_req != 0) ? lim_of(lim_ext, m_ph) : lim_of(lim_norm, m_ph);
      if (tick_en && !hold && m_cnt >= lim) begin
        m_cnt = 0; m_ph = (m_ph + 1) % NPHASE; m_done = 1; m_req = int'(button);
      end else begin
        if (tick_en && !hold) m_cnt = m_cnt + 1;
        m_done = 0;
        if (button) m_req = 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("model.count", int'(count), m_cnt);
      chk("model.phase", int'(phase), m_ph);
      chk("model.done",  int'(phase_done), m_done);
      chk("model.req",   int'(req_pending), m_req);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [NPHASE*WIDTH-1:0] pack4(input int p0, p1, p2, p3);
    logic [NPHASE*WIDTH-1:0] v;
    v = '0;
    v[0*WIDTH +: WIDTH] = WIDTH'(p0);
    v[1*WIDTH +: WIDTH] = WIDTH'(p1);
    v[2*WIDTH +: WIDTH] = WIDTH'(p2);
    v[3*WIDTH +: WIDTH] = WIDTH'(p3);
    return v;
  endfunction

  initial begin
    reset = 1'b1; clear = 1'b0; tick_en = 1'b0; hold = 1'b0; button = 1'b0;
    lim_norm = pack4(29, 3, 29, 3);
    lim_ext  = pack4(33, 7, 29, 3);
    clks(2);
    chk("rst.count", int'(count), 0);
    chk("rst.phase", int'(phase), 0);
    chk("rst.done",  int'(phase_done), 0);
    chk("rst.req",   int'(req_pending), 0);
    reset = 1'b0;
    run_cmp = 1'b1;
    clks(1);

    // 1: free-running cycle 30/4/30/4
    tick_en = 1'b1;
    clks(29);
    chk("t1.no_done_early", int'(phase_done), 0);
    chk("t1.count29", int'(count), 29);
    clks(1);
    chk("t1.done_p0", int'(phase_done), 1);
    chk("t1.phase1", int'(phase), 1);
    clks(4);
    chk("t1.phase2", int'(phase), 2);
    clks(30);
    chk("t1.phase3", int'(phase), 3);
    clks(4);
    chk("t1.wrap0", int'(phase), 0);
    chk("t1.wrap_done", int'(phase_done), 1);

    // 2: button at count 5 extends phase 0 to 34 ticks
    clks(5);
    chk("t2.count5", int'(count), 5);
    button = 1'b1; clks(1); button = 1'b0;
    chk("t2.req_set", int'(req_pending), 1);
    clks(27);
    chk("t2.still_p0", int'(phase), 0);
    chk("t2.count33", int'(count), 33);
    clks(1);
    chk("t2.phase1", int'(phase), 1);
    chk("t2.req_drop", int'(req_pending), 0);

    // 3: press on the terminal clock of phase 0 carries into phase 1
    clks(38);
    chk("t3.at_p0", int'(phase), 0);
    clks(29);
    button = 1'b1; clks(1); button = 1'b0;
    chk("t3.phase1", int'(phase), 1);
    chk("t3.req_kept", int'(req_pending), 1);
    clks(7);
    chk("t3.ext_p1", int'(phase), 1);
    clks(1);
    chk("t3.phase2", int'(phase), 2);
    chk("t3.req_drop", int'(req_pending), 0);

    // 4: lower phase 0 limit below the running count
    clks(34);
    chk("t4.at_p0", int'(phase), 0);
    clks(20);
    chk("t4.count20", int'(count), 20);
    lim_norm = pack4(10, 3, 29, 3);
    clks(1);
    chk("t4.count0", int'(count), 0);
    chk("t4.phase1", int'(phase), 1);
    lim_norm = pack4(29, 3, 29, 3);

    // 5: hold freezes count/phase but request still latches
    clks(2);
    chk("t5.count2", int'(count), 2);
    hold = 1'b1;
    clks(3);
    button = 1'b1; clks(1); button = 1'b0;
    clks(4);
    chk("t5.frozen_cnt", int'(count), 2);
    chk("t5.frozen_ph", int'(phase), 1);
    chk("t5.req_hold", int'(req_pending), 1);
    hold = 1'b0;
    clks(6);
    chk("t5.ext_end", int'(phase), 2);

    // 6a: clear restarts and drops request
    button = 1'b1; clks(1); button = 1'b0;
    clear = 1'b1; button = 1'b1; clks(1); clear = 1'b0; button = 1'b0;
    chk("t6.clr_cnt", int'(count), 0);
    chk("t6.clr_ph", int'(phase), 0);
    chk("t6.clr_req", int'(req_pending), 0);
    clks(51);
    chk("t6.p2_cnt17", int'(count), 17);
    chk("t6.p2", int'(phase), 2);
    button = 1'b1; clks(1); button = 1'b0;
    chk("t6.req_pre_rst", int'(req_pending), 1);

    // 6b: async reset mid-cycle
    #2 reset = 1'b1;
    #1;
    chk("t6.arst_cnt", int'(count), 0);
    chk("t6.arst_ph", int'(phase), 0);
    chk("t6.arst_req", int'(req_pending), 0);
    chk("t6.arst_done", int'(phase_done), 0);
    clks(1);
    reset = 1'b0;
    clks(3);
    chk("t6.resume", int'(count), 3);
    clks(27);
    chk("t6.resume_done", int'(phase_done), 1);

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
